fft_ctrl2048: RTL and testbench
===============================

# fft_ctrl2048

Top-level sequencer for the 2048-point in-place radix-2 FFT core. It accepts a frame of samples into the working memory, then steps the butterfly addresser (`fftaddr2048`) through 11 stages × 1024 butterflies, one read/wait/write cycle group per butterfly. Finally it streams the result memory out. It owns the addresser's enable, writemode and reset, the load/unload address counters and the frame-level handshakes.

## Interface
- `BF_LAT`, default 4: cycles from read addresses presented to butterfly result valid; legal range 1..15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a frame; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: high only in LOAD.
- `load_addr` out 11: natural-order write address for the input sample.
- `load_we` out 1: equals `in_valid & in_ready`.
- `addr_reset` out 1: reset to addresser index.
- `addr_enable` out 1: addresser advance.
- `addr_writemode` out 1: addresser write phase.
- `bf_start` out 1: pulse marking the butterfly read cycle.
- `stage` out 4: current stage, 0..10.
- `out_valid` out 1: output sample address valid.
- `out_ready` in 1: downstream accepts.
- `out_addr` out 11: natural-order read address for unload.

## Operation
- States: IDLE, LOAD, RD, WT, WR, UNLOAD, DONE.
- IDLE → LOAD on `start`. `addr_reset`=1 in that transition cycle. `load_addr` and butterfly count `bf_cnt` (10 bits) are cleared. `stage` is cleared.
- LOAD:
  - Each `in_valid & in_ready` writes one sample and increments `load_addr`.
  - On the handshake with `load_addr`=2047 → RD.
  - `in_valid` outside LOAD is ignored.
- RD: `bf_start`=1, `addr_enable`=0, `addr_writemode`=0. → WT, with the wait counter loaded to BF_LAT-1.
- WT: enable and writemode stay 0, so addresses hold. Count down; at 0 → WR.
- WR: `addr_writemode`=1, `addr_enable`=1. The addresser index advances by 2.
  - If `bf_cnt`≠1023: `bf_cnt`++ and → RD.
  - If `bf_cnt`=1023 and `stage`≠10: `bf_cnt` wraps to 0, `stage`++, → RD.
  - If `bf_cnt`=1023 and `stage`=10 → UNLOAD, with `out_addr` cleared.
- UNLOAD:
  - `out_valid`=1 and `out_addr` is held stable until `out_valid & out_ready`, then it increments.
  - On the handshake at `out_addr`=2047 → DONE.
  - Read-data alignment is the downstream memory's responsibility.
- DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Widths: all counters wrap naturally. No arithmetic beyond increment and decrement.

## Timing
- Reset values: all outputs 0. `stage`=0, `load_addr`=0, `out_addr`=0, state IDLE.
- Reset mid-frame: returns to IDLE on the next edge; partial frame discarded. `addr_reset` is driven high combinationally while `reset`=1.
- Butterfly period is BF_LAT+2 cycles.
- Compute phase is 11·1024·(BF_LAT+2) cycles; for BF_LAT=4 that is 67584.
- Minimum frame with no back-pressure: 1 + 2048 + compute + 2048 + 1 cycles.
- `load_addr` and `out_addr` are registered. They are valid in the same cycle as `in_ready` and `out_valid` respectively.
- The addresser sees `addr_enable` only in WR. Its memory addresses during RD, WT and WR are those of the same butterfly.

## Structure
- Shared package `fft2048_pkg` holds:
  - state enum `fft_ctrl_state_t`;
  - constants `FFT_N`=2048, `FFT_LOG2N`=11, `FFT_NBF`=1024, `FFT_LAST_STAGE`=10.
- No sub-module. The wait counter and the three address/count counters are inline.
- The addresser is instantiated by the parent, not inside this block.

## Test plan
- **Reset and idle:** assert `reset` 2 cycles, then hold `in_valid`=1 with no `start` → all outputs 0, `in_ready`=0, no `load_we`.
- **Load with gaps:** `start`, then 2048 samples with `in_valid` toggling every other cycle → `load_addr` 0..2047 in order, exactly 2048 `load_we`, RD entered on the cycle after the last handshake.
- **Compute cadence, BF_LAT=4:**
  - `bf_start` every 6 cycles;
  - `addr_enable`/`addr_writemode` high only 5 cycles after each `bf_start`;
  - `stage` increments after every 1024th WR;
  - 11264 WR pulses in total.
- **Unload back-pressure:** `out_ready` random 50% → `out_addr` never changes without a handshake, reaches 2047, then `done` pulses once and `busy` falls on the next cycle.
- **Mid-compute reset:** `reset` at stage 5, `bf_cnt` 300 → next cycle IDLE, all outputs 0. A new `start` then produces a correct full frame with `addr_reset` pulsed.
- **Ignored start:** `start` asserted during LOAD and UNLOAD → no effect on counters and no second `addr_reset`.

Source files
------------

// File: rtl/fft2048_pkg.sv
// Shared types and constants for the 2048-point radix-2 FFT core.
package fft2048_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD,
        WT,
        WR,
        UNLOAD,
        DONE
    } fft_ctrl_state_t;

    localparam int unsigned FFT_N          = 2048;
    localparam int unsigned FFT_LOG2N      = 11;
    localparam int unsigned FFT_NBF        = 1024;
    localparam int unsigned FFT_LAST_STAGE = 10;

endpackage

// File: rtl/fft_ctrl2048.sv
// Frame sequencer for the 2048-point FFT: load, 11 x 1024 butterflies
// (read / wait / write per butterfly), then unload.
module fft_ctrl2048
    import fft2048_pkg::*;
#(
    parameter int unsigned BF_LAT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] load_addr,
    output logic        load_we,
    output logic        addr_reset,
    output logic        addr_enable,
    output logic        addr_writemode,
    output logic        bf_start,
    output logic [3:0]  stage,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_addr
);

    localparam logic [3:0]  WAIT_INIT  = 4'(BF_LAT - 1);
    localparam logic [9:0]  LAST_BF    = 10'(FFT_NBF - 1);
    localparam logic [3:0]  LAST_STAGE = 4'(FFT_LAST_STAGE);
    localparam logic [10:0] LAST_ADDR  = 11'(FFT_N - 1);

    fft_ctrl_state_t state, state_next;
    logic [9:0] bf_cnt;
    logic [3:0] wait_cnt;

    always_comb begin
        state_next     = state;
        busy           = 1'b0;
        done           = 1'b0;
        in_ready       = 1'b0;
        addr_reset     = 1'b0;
        addr_enable    = 1'b0;
        addr_writemode = 1'b0;
        bf_start       = 1'b0;
        out_valid      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    addr_reset = 1'b1;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && load_addr == LAST_ADDR) begin
                    state_next = RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                bf_start   = 1'b1;
                state_next = WT;
            end
            WT: begin
                busy = 1'b1;
                if (wait_cnt == '0) begin
                    state_next = WR;
                end
            end
            WR: begin
                busy           = 1'b1;
                addr_enable    = 1'b1;
                addr_writemode = 1'b1;
                if (bf_cnt == LAST_BF && stage == LAST_STAGE) begin
                    state_next = UNLOAD;
                end else begin
                    state_next = RD;
                end
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && out_addr == LAST_ADDR) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // The addresser is held in reset for as long as the controller is.
        if (reset) begin
            addr_reset = 1'b1;
        end
        load_we = in_valid & in_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            load_addr <= '0;
            out_addr  <= '0;
            bf_cnt    <= '0;
            stage     <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        load_addr <= '0;
                        bf_cnt    <= '0;
                        stage     <= '0;
                    end
                end
                LOAD: begin
                    if (load_we) begin
                        load_addr <= load_addr + 1'b1;
                    end
                end
                RD: wait_cnt <= WAIT_INIT;
                WT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WR: begin
                    // bf_cnt wraps to 0 naturally after the 1024th butterfly.
                    bf_cnt <= bf_cnt + 1'b1;
                    if (bf_cnt == LAST_BF) begin
                        if (stage != LAST_STAGE) begin
                            stage <= stage + 1'b1;
                        end else begin
                            out_addr <= '0;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        out_addr <= out_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl2048.sv
// Self-checking bench for fft_ctrl2048: reset/idle vector table, a frame
// aborted by reset mid-compute, then a full frame with gaps and back-pressure.
module tb_fft_ctrl2048;

    localparam int BF_LAT   = 2;
    localparam int P        = BF_LAT + 2;
    localparam int COMP_CYC = 11 * 1024 * P;

    localparam int M_IDLE   = 0;
    localparam int M_LOAD   = 1;
    localparam int M_COMP   = 2;
    localparam int M_UNLOAD = 3;
    localparam int M_DONE   = 4;

    logic        clock = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic        busy, done, in_ready, load_we, addr_reset;
    logic        addr_enable, addr_writemode, bf_start, out_valid;
    logic [10:0] load_addr, out_addr;
    logic [3:0]  stage;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        in_ready;
        logic        load_we;
        logic        addr_reset;
        logic        addr_enable;
        logic        addr_writemode;
        logic        bf_start;
        logic        out_valid;
        logic [3:0]  stage;
        logic [10:0] load_addr;
        logic [10:0] out_addr;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  st;
        logic  iv;
        logic  ordy;
        outs_t exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: frame phase plus plain counters; the compute phase is
    // derived purely from the elapsed cycle count.
    int m_phase, m_nload, m_k, m_nout, m_stage;
    int n_we, n_wr, n_bfs, n_done, n_arst;

    fft_ctrl2048 #(.BF_LAT(BF_LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load_addr      (load_addr),
        .load_we        (load_we),
        .addr_reset     (addr_reset),
        .addr_enable    (addr_enable),
        .addr_writemode (addr_writemode),
        .bf_start       (bf_start),
        .stage          (stage),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr)
    );

    always #5 clock = ~clock;

    function automatic outs_t mk(input logic [8:0] flags, input int stg, input int la, input int oa);
        outs_t o;
        o = {flags, 4'(stg), 11'(la), 11'(oa)};
        return o;
    endfunction

    function automatic outs_t actual();
        outs_t a;
        a = {busy, done, in_ready, load_we, addr_reset, addr_enable,
             addr_writemode, bf_start, out_valid, stage, load_addr, out_addr};
        return a;
    endfunction

    task automatic check(input string nm, input outs_t e);
        outs_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, a, e);
        end
    endtask

    task automatic check_cnt(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic iv,
                              input logic ordy, output outs_t e);
        e           = '0;
        e.load_addr = 11'(m_nload);
        e.out_addr  = 11'(m_nout);
        e.stage     = 4'(m_stage);
        e.busy      = (m_phase != M_IDLE);
        case (m_phase)
            M_IDLE: e.addr_reset = s;
            M_LOAD: begin
                e.in_ready = 1'b1;
                e.load_we  = iv;
            end
            M_COMP: begin
                e.stage          = 4'(m_k / (1024 * P));
                e.bf_start       = (m_k % P == 0);
                e.addr_enable    = (m_k % P == P - 1);
                e.addr_writemode = (m_k % P == P - 1);
            end
            M_UNLOAD: e.out_valid = 1'b1;
            M_DONE:   e.done = 1'b1;
            default: ;
        endcase
        if (r) e.addr_reset = 1'b1;

        if (r) begin
            m_phase = M_IDLE;
            m_nload = 0;
            m_nout  = 0;
            m_stage = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (s) begin
                    m_phase = M_LOAD;
                    m_nload = 0;
                    m_stage = 0;
                end
                M_LOAD: if (iv) begin
                    m_nload++;
                    if (m_nload == 2048) begin
                        m_phase = M_COMP;
                        m_k     = 0;
                    end
                end
                M_COMP: begin
                    m_stage = m_k / (1024 * P);
                    m_k++;
                    if (m_k == COMP_CYC) begin
                        m_phase = M_UNLOAD;
                        m_nout  = 0;
                    end
                end
                M_UNLOAD: if (ordy) begin
                    m_nout++;
                    if (m_nout == 2048) m_phase = M_DONE;
                end
                M_DONE: m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic iv,
                         input logic ordy, input string nm);
        outs_t e;
        reset     = r;
        start     = s;
        in_valid  = iv;
        out_ready = ordy;
        model_step(r, s, iv, ordy, e);
        #2;
        check(nm, e);
        if (load_we === 1'b1) n_we++;
        if (addr_enable === 1'b1 && addr_writemode === 1'b1) n_wr++;
        if (bf_start === 1'b1) n_bfs++;
        if (done === 1'b1) n_done++;
        if (addr_reset === 1'b1) n_arst++;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    vec_t tbl[10];

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // rst st iv ordy | busy done in_rdy we arst en wm bfs ov, stage, load_addr, out_addr
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(9'b000010000, 0, 0, 0)};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, mk(9'b000010000, 0, 0, 0)};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(9'b000000000, 0, 0, 0)};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, mk(9'b000000000, 0, 0, 0)};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(9'b000010000, 0, 0, 0)};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(9'b101000000, 0, 0, 0)};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(9'b101100000, 0, 0, 0)};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(9'b101100000, 0, 1, 0)};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(9'b101010000, 0, 2, 0)};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(9'b000000000, 0, 0, 0)};

        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < 10; i++) begin
            reset     = tbl[i].rst;
            start     = tbl[i].st;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #2;
            check($sformatf("vec%0d", i), tbl[i].exp);
            @(posedge clock);
            #1;
            cyc++;
        end

        m_phase = M_IDLE;
        m_nload = 0;
        m_nout  = 0;
        m_stage = 0;
        m_k     = 0;

        // Frame A: continuous load, ignored starts, reset at stage 5 / butterfly 300.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "frameA_start");
        while (m_phase == M_LOAD)
            cycle(1'b0, $urandom_range(0, 15) == 0, 1'b1, 1'b0, "frameA_load");
        while (m_phase == M_COMP && m_k != 5 * 1024 * P + 300 * P)
            cycle(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, "frameA_comp");
        check_cnt("frameA_reached_reset_point", m_k, 5 * 1024 * P + 300 * P);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, "midreset_cycle");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "after_midreset");

        // Frame B: gapped load, full compute, random back-pressure on unload.
        n_we   = 0;
        n_wr   = 0;
        n_bfs  = 0;
        n_done = 0;
        n_arst = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "frameB_start");
        for (int c = 0; c < 90000 && m_phase != M_IDLE; c++)
            cycle(1'b0, $urandom_range(0, 31) == 0, (c % 2) == 1,
                  $urandom_range(0, 1) == 1, "frameB");
        check_cnt("frameB_completed", m_phase, M_IDLE);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "idle_after_done");

        check_cnt("load_we_count", n_we, 2048);
        check_cnt("wr_pulse_count", n_wr, 11 * 1024);
        check_cnt("bf_start_count", n_bfs, 11 * 1024);
        check_cnt("done_count", n_done, 1);
        check_cnt("addr_reset_count", n_arst, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
